// File: rtl/sram_port_arbiter_if.sv
// Request/response bundle for one master of sram_port_arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_ready;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-master front end for a 2R1W SRAM: dedicated read ports, round-robin write port.
// Optional macro SRAM_ARB_FWD_EN: a read captures a same-cycle granted write to its address.
module sram_port_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    sram_port_arbiter_if.slave  m0,
    sram_port_arbiter_if.slave  m1,
    output logic [ADDR_W-1:0]   mem_read1_addr,
    output logic [ADDR_W-1:0]   mem_read2_addr,
    input  logic [DATA_W-1:0]   mem_read1_data,
    input  logic [DATA_W-1:0]   mem_read2_data,
    output logic [ADDR_W-1:0]   mem_write_addr,
    output logic [DATA_W-1:0]   mem_write_data,
    output logic                mem_write_enable
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

    logic [1:0]        req_valid, req_we, rsp_ready, req_ready, rsp_valid;
    logic [1:0]        wr_req, wr_grant;
    logic [ADDR_W-1:0] req_addr  [2];
    logic [DATA_W-1:0] req_wdata [2];
    logic [DATA_W-1:0] rd_data   [2];
    logic [DATA_W-1:0] rsp_rdata [2];
    logic              rr_prio_reg, rr_prio_next;

    assign req_valid    = {m1.req_valid, m0.req_valid};
    assign req_we       = {m1.req_we, m0.req_we};
    assign rsp_ready    = {m1.rsp_ready, m0.rsp_ready};
    assign req_addr[0]  = m0.req_addr;
    assign req_addr[1]  = m1.req_addr;
    assign req_wdata[0] = m0.req_wdata;
    assign req_wdata[1] = m1.req_wdata;
    assign rd_data[0]   = mem_read1_data;
    assign rd_data[1]   = mem_read2_data;

    assign m0.req_ready = req_ready[0];
    assign m1.req_ready = req_ready[1];
    assign m0.rsp_valid = rsp_valid[0];
    assign m1.rsp_valid = rsp_valid[1];
    assign m0.rsp_rdata = rsp_rdata[0];
    assign m1.rsp_rdata = rsp_rdata[1];

    assign mem_read1_addr = m0.req_addr;
    assign mem_read2_addr = m1.req_addr;

    // No write is granted while reset is held, so a toggling bus cannot corrupt the SRAM.
    always_comb begin
        wr_req       = req_valid & req_we & {2{~reset}};
        wr_grant[0]  = wr_req[0] && (!wr_req[1] || !rr_prio_reg);
        wr_grant[1]  = wr_req[1] && (!wr_req[0] ||  rr_prio_reg);
        rr_prio_next = (&wr_req) ? ~rr_prio_reg : rr_prio_reg;
    end

    always_comb begin
        mem_write_enable = |wr_grant;
        mem_write_addr   = '0;
        mem_write_data   = '0;
        if (wr_grant[0]) begin
            mem_write_addr = req_addr[0];
            mem_write_data = req_wdata[0];
        end else if (wr_grant[1]) begin
            mem_write_addr = req_addr[1];
            mem_write_data = req_wdata[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rr_prio_reg <= 1'b0;
        else       rr_prio_reg <= rr_prio_next;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            slot_state_t       state_reg, state_next;
            logic [DATA_W-1:0] rdata_reg, rdata_next, capture_data;
            logic              slot_free, rd_accept;

            // Draining the current response frees the slot in the same cycle.
            assign slot_free      = (state_reg == EMPTY) || rsp_ready[gi];
            assign rd_accept      = req_valid[gi] && !req_we[gi] && slot_free;
            assign req_ready[gi]  = req_we[gi] ? wr_grant[gi] : slot_free;
            assign rsp_valid[gi]  = (state_reg == FULL);
            assign rsp_rdata[gi]  = rdata_reg;

`ifdef SRAM_ARB_FWD_EN
            localparam int OI = 1 - gi;
            assign capture_data = (wr_grant[OI] && (req_addr[OI] == req_addr[gi]))
                                  ? req_wdata[OI] : rd_data[gi];
`else
            assign capture_data = rd_data[gi];
`endif

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg <= EMPTY;
                    rdata_reg <= '0;
                end else begin
                    state_reg <= state_next;
                    rdata_reg <= rdata_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                rdata_next = rdata_reg;
                if (rd_accept) begin
                    state_next = FULL;
                    rdata_next = capture_data;
                end else if (state_reg == FULL && rsp_ready[gi]) begin
                    state_next = EMPTY;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter against a behavioural model
// holding the expected memory image, response slots and write priority.
module tb_sram_port_arbiter;
    localparam int AW = 7;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] mem_read1_addr, mem_read2_addr, mem_write_addr;
    logic [DW-1:0] mem_read1_data, mem_read2_data, mem_write_data;
    logic          mem_write_enable;

    sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
    sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk              (clk),
        .reset            (reset),
        .m0               (m0_if),
        .m1               (m1_if),
        .mem_read1_addr   (mem_read1_addr),
        .mem_read2_addr   (mem_read2_addr),
        .mem_read1_data   (mem_read1_data),
        .mem_read2_data   (mem_read2_data),
        .mem_write_addr   (mem_write_addr),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable)
    );

    always #5 clk = ~clk;

    // SRAM the arbiter drives: async reads, write committed on the edge.
    logic [DW-1:0] sram [128];
    assign mem_read1_data = sram[mem_read1_addr];
    assign mem_read2_data = sram[mem_read2_addr];
    always @(posedge clk) if (mem_write_enable) sram[mem_write_addr] <= mem_write_data;

    // Reference model state
    logic [DW-1:0] ref_mem [128];
    bit            exp_valid [2];
    logic [DW-1:0] exp_data  [2];
    bit            exp_prio;

    int n_checks = 0;
    int n_pass   = 0;
    logic last_rdy0, last_rdy1, last_mwe;
    logic [AW-1:0] last_waddr;

`ifdef SRAM_ARB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock of stimulus: drive, check combinational outputs, advance model, check registered outputs.
    task automatic step(input bit rst,
                        input bit v0, input bit we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0, input bit rr0,
                        input bit v1, input bit we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1, input bit rr1);
        bit            v [2], we [2], rr [2], wq [2];
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        int            g;
        v[0] = v0; we[0] = we0; a[0] = a0; d[0] = d0; rr[0] = rr0;
        v[1] = v1; we[1] = we1; a[1] = a1; d[1] = d1; rr[1] = rr1;
        reset = rst;
        m0_if.req_valid = v0; m0_if.req_we = we0; m0_if.req_addr = a0; m0_if.req_wdata = d0; m0_if.rsp_ready = rr0;
        m1_if.req_valid = v1; m1_if.req_we = we1; m1_if.req_addr = a1; m1_if.req_wdata = d1; m1_if.rsp_ready = rr1;
        #1;
        for (int i = 0; i < 2; i++) wq[i] = !rst && v[i] && we[i];
        if (wq[0] && wq[1]) g = int'(exp_prio);
        else if (wq[0])     g = 0;
        else if (wq[1])     g = 1;
        else                g = -1;
        check("m0_req_ready", {31'd0, m0_if.req_ready}, we[0] ? {31'd0, g == 0} : {31'd0, !exp_valid[0] || rr[0]});
        check("m1_req_ready", {31'd0, m1_if.req_ready}, we[1] ? {31'd0, g == 1} : {31'd0, !exp_valid[1] || rr[1]});
        check("mem_write_enable", {31'd0, mem_write_enable}, {31'd0, g >= 0});
        check("mem_write_addr", {25'd0, mem_write_addr}, (g >= 0) ? {25'd0, a[g]} : 32'd0);
        check("mem_write_data", mem_write_data, (g >= 0) ? d[g] : 32'd0);
        check("mem_read1_addr", {25'd0, mem_read1_addr}, {25'd0, a0});
        check("mem_read2_addr", {25'd0, mem_read2_addr}, {25'd0, a1});
        last_rdy0 = m0_if.req_ready; last_rdy1 = m1_if.req_ready;
        last_mwe = mem_write_enable; last_waddr = mem_write_addr;
        if (rst) begin
            exp_valid[0] = 0; exp_valid[1] = 0;
            exp_data[0] = '0; exp_data[1] = '0;
            exp_prio = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (v[i] && !we[i] && (!exp_valid[i] || rr[i])) begin
                    exp_valid[i] = 1;
                    if (FWD && g == 1 - i && a[g] == a[i]) exp_data[i] = d[g];
                    else                                   exp_data[i] = ref_mem[a[i]];
                end else if (exp_valid[i] && rr[i]) begin
                    exp_valid[i] = 0;
                end
            end
            if (wq[0] && wq[1]) exp_prio = !exp_prio;
            if (g >= 0) ref_mem[a[g]] = d[g];
        end
        @(negedge clk);
        check("m0_rsp_valid", {31'd0, m0_if.rsp_valid}, {31'd0, exp_valid[0]});
        check("m0_rsp_rdata", m0_if.rsp_rdata, exp_data[0]);
        check("m1_rsp_valid", {31'd0, m1_if.rsp_valid}, {31'd0, exp_valid[1]});
        check("m1_rsp_rdata", m1_if.rsp_rdata, exp_data[1]);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    endtask

    task automatic rand_step(input bit rst, input int amax);
        step(rst,
             1'($urandom), 1'($urandom), AW'($urandom_range(amax)), $urandom, 1'($urandom_range(3) != 0),
             1'($urandom), 1'($urandom), AW'($urandom_range(amax)), $urandom, 1'($urandom_range(3) != 0));
        $display("cycle rst=%0d m0 v=%0d we=%0d a=%0d | m1 v=%0d we=%0d a=%0d | wen=%0d waddr=%0d",
                 rst, m0_if.req_valid, m0_if.req_we, m0_if.req_addr,
                 m1_if.req_valid, m1_if.req_we, m1_if.req_addr, last_mwe, last_waddr);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            sram[i] = '0;
            ref_mem[i] = '0;
        end
        exp_valid[0] = 0; exp_valid[1] = 0;
        exp_data[0] = '0; exp_data[1] = '0;
        exp_prio = 0;
        reset = 1'b1;
        @(negedge clk);

        // Reset with toggling inputs
        rand_step(1, 127);
        rand_step(1, 127);
        check("rst_m0_valid", {31'd0, m0_if.rsp_valid}, 32'd0);
        check("rst_m1_rdata", m1_if.rsp_rdata, 32'd0);
        idle();
        check("rst_mwe", {31'd0, last_mwe}, 32'd0);

        // Single write, then read from the other master
        step(0, 1, 1, 5, 32'hDEADBEEF, 1, 0, 0, 0, 0, 1);
        check("w5_ready", {31'd0, last_rdy0}, 32'd1);
        check("w5_mwe", {31'd0, last_mwe}, 32'd1);
        step(0, 0, 0, 0, 0, 1, 1, 0, 5, 0, 1);
        check("r5_valid", {31'd0, m1_if.rsp_valid}, 32'd1);
        check("r5_rdata", m1_if.rsp_rdata, 32'hDEADBEEF);

        // Contention: first goes to M0, loser follows, next contention goes to M1
        step(0, 1, 1, 1, 32'h11, 1, 1, 1, 2, 32'h22, 1);
        check("cont1_m0_rdy", {31'd0, last_rdy0}, 32'd1);
        check("cont1_m1_rdy", {31'd0, last_rdy1}, 32'd0);
        step(0, 0, 0, 0, 0, 1, 1, 1, 2, 32'h22, 1);
        check("cont1_m1_late", {31'd0, last_rdy1}, 32'd1);
        step(0, 1, 1, 3, 32'h33, 1, 1, 1, 4, 32'h44, 1);
        check("cont2_m1_rdy", {31'd0, last_rdy1}, 32'd1);
        check("cont2_waddr", {25'd0, last_waddr}, 32'd4);
        step(0, 1, 1, 3, 32'h33, 1, 0, 0, 0, 0, 1);
        check("cont2_m0_late", {31'd0, last_rdy0}, 32'd1);

        // Back-pressure on M0 responses
        step(0, 1, 0, 3, 0, 1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 4, 0, 0, 0, 0, 0, 0, 1);
            check("bp_m0_rdy", {31'd0, last_rdy0}, 32'd0);
            check("bp_hold", m0_if.rsp_rdata, 32'h33);
        end
        step(0, 1, 0, 4, 0, 1, 0, 0, 0, 0, 1);
        check("bp_accept", {31'd0, last_rdy0}, 32'd1);
        check("bp_next", m0_if.rsp_rdata, 32'h44);
        idle();

        // Same-address write/read collision
        step(0, 1, 1, 9, 32'h99, 1, 1, 0, 9, 0, 1);
        check("collide_r9", m1_if.rsp_rdata, FWD ? 32'h99 : 32'h0);
        idle();

        // Reset drops a stalled response and restores priority
        step(0, 1, 1, 20, 32'hA0, 1, 1, 1, 21, 32'hA1, 1);
        step(0, 0, 0, 0, 0, 1, 1, 0, 21, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        check("stall_m1_valid", {31'd0, m1_if.rsp_valid}, 32'd1);
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        check("rst_mid_m1_valid", {31'd0, m1_if.rsp_valid}, 32'd0);
        step(0, 1, 1, 30, 32'hB0, 1, 1, 1, 31, 32'hB1, 1);
        check("rst_prio_m0", {31'd0, last_rdy0}, 32'd1);
        idle();

        // Random traffic over a narrow address range to force collisions
        for (int n = 0; n < 400; n++) rand_step($urandom_range(49) == 0, 7);
        for (int n = 0; n < 100; n++) rand_step(0, 127);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the 128x32 SRAM (two async read ports, one sync write port) between two requesters, M0 and M1.
- Each master gets a dedicated read port: M0 uses read port 1, M1 uses read port 2.
- Round-robin arbitration for the single write port.
- Read responses are registered with a valid/ready handshake and back-pressure.
- Sits between the core's fetch/load-store units and the SRAM.

Parameters:
ADDR_W, 7, address width (128 words)
DATA_W, 32, data width

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
mN_req_valid  in  1  request valid (N = 0, 1; applies to every mN_ line)
mN_req_we  in  1  1 = write, 0 = read
mN_req_addr  in  ADDR_W  word address
mN_req_wdata  in  DATA_W  write data
mN_req_ready  out  1  request accepted this cycle when valid and ready are both high
mN_rsp_valid  out  1  read data valid
mN_rsp_rdata  out  DATA_W  read data
mN_rsp_ready  in  1  master accepts response
mem_read1_addr  out  ADDR_W  to SRAM read port 1
mem_read2_addr  out  ADDR_W  to SRAM read port 2
mem_read1_data  in  DATA_W  from SRAM read port 1
mem_read2_data  in  DATA_W  from SRAM read port 2
mem_write_addr  out  ADDR_W  to SRAM write port
mem_write_data  out  DATA_W  to SRAM write port
mem_write_enable  out  1  SRAM write strobe

Behaviour:
- One clock (clk). Reset is synchronous, active-high, on port "reset".
- Reset values:
  - mN_rsp_valid = 0, mN_rsp_rdata = 0.
  - Priority pointer rr_prio = 0 (M0 favoured).
  - All pending responses are dropped. Reset mid-operation clears rsp_valid at that clock edge.
- Read address paths are combinational pass-through: mem_read1_addr = m0_req_addr, mem_read2_addr = m1_req_addr, every cycle.
- Per-master response slot, two states:
  - States: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - Read ready: mN_req_ready = !mN_rsp_valid || mN_rsp_ready. This frees the slot the same cycle, so a full-throughput read stream is possible.
  - Read accepted (valid & !we & ready): at the next posedge the slot goes FULL and rsp_rdata captures the SRAM read data. Latency is 1 cycle.
  - FULL with rsp_ready=1 and no new read accepted: slot goes EMPTY at the next posedge.
  - FULL with rsp_ready=0: rsp_valid and rsp_rdata are held stable and the read is stalled.
- Writes produce no response and ignore the slot state. Write ready is the write grant (combinational).
- Write arbitration:
  - Only one master requesting a write: it is granted.
  - Both masters requesting: grant master rr_prio. At the posedge, rr_prio becomes the other master.
  - rr_prio changes only on contention.
  - The loser holds its request; it is granted the next cycle at the latest.
- Write port drive:
  - When granted: mem_write_enable = 1, with addr/data taken from the granted master, combinationally in the same cycle. The SRAM commits at the next posedge.
  - No grant: mem_write_enable = 0, mem_write_addr = 0, mem_write_data = 0.
- A request's we bit selects the path. A master cannot issue a read and a write in the same cycle.
- Read/write to the same address in the same cycle (other master's granted write):
  - Default: the read returns the old data (read-before-write).
  - Forwarding behaviour is under the optional feature below.
- Same-address writes from both masters in one cycle: serialized per arbitration. The later-granted data persists.
- Address wrap: none; all ADDR_W values are valid.

Optional Feature:
- Macro SRAM_ARB_FWD_EN.
- Defined: if a read is accepted in a cycle where the other master's granted write targets the same address, rsp_rdata captures that write's data instead of the SRAM read data (write-first semantics).
- Undefined: read-before-write; rsp_rdata always captures the SRAM read port data.

Test Plan:
- Reset: assert reset 2 cycles with all inputs toggling. Required: m0/m1_rsp_valid = 0, rsp_rdata = 0, mem_write_enable = 0; first contention goes to M0.
- M0 write addr 5 = 0xDEADBEEF (M1 idle). Required: m0_req_ready = 1 and mem_write_enable = 1 in the same cycle. Then M1 reads addr 5: m1_rsp_valid = 1 one cycle later with rdata 0xDEADBEEF.
- Both masters write in cycle T (M0 addr 1 = 0x11, M1 addr 2 = 0x22). Required: T grants M0, m1_req_ready = 0; T+1 grants M1. Next contention (M0 addr 3 = 0x33, M1 addr 4 = 0x44) grants M1 first.
- M0 reads addr 3 (0x33) with m0_rsp_ready = 0 for 3 cycles while issuing a second read of addr 4. Required: m0_rsp_valid stays 1, rdata stays 0x33, m0_req_ready = 0. Once rsp_ready = 1, addr 4 is accepted and 0x44 is presented the next cycle.
- M0 writes addr 9 = 0x99 while M1 reads addr 9 (old value 0). Required: M1's response is 0x0 without SRAM_ARB_FWD_EN and 0x99 with it.
- M1 response pending with rsp_ready = 0, then reset asserted for 1 cycle. Required: m1_rsp_valid = 0 after that edge, and rr_prio is back to M0.
